display_scan_ctrl: RTL

Time-multiplexing controller that shares the single combinational BCD-to-7-segment decoder among four common-anode digits of the irrigation-system display. It holds a double-buffered 4-digit value, presents one digit's 4-bit code to the decoder inputs at a time, and drives active-low digit enables. Its timing includes a dead band between slots to prevent ghosting, plus per-digit blanking and blinking. Updates from the system controller take effect only at frame boundaries, so the display never shows a torn value.

---
 rtl/display_scan_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexes one BCD-to-7-segment decoder across four common-anode
// digits. A double-buffered 4-digit value (shadow -> active) is swapped only
// at frame boundaries, so a load can never show up half-applied. Each digit
// slot opens with a short dead band (all digits off) to stop ghosting. Each
// digit can also be blanked through en, or blinked through blink_mask.
//
// Ports
//   clk         system clock, single domain
//   rst_n       asynchronous active-low reset
//   load        single-cycle strobe; captures din
//   din[15:0]   four BCD codes, digit0 in [3:0] ... digit3 in [15:12]
//   en[3:0]     per-digit enable (1 = shown), sampled live
//   blink_mask  per-digit blink select, sampled live
//   code[3:0]   to decoder inputs, code[3] = A (MSB)
//   dig_n[3:0]  digit enables, active low, at most one low
//   pending     shadow holds a value not yet displayed
//   frame_tick  one-cycle pulse on the last cycle of each frame
//
// Handshake: load is a plain strobe with no ready. Every cycle with load
// high is accepted, and a later load overwrites an earlier one.
//
// All outputs are flops. Their next values come from the next-state values
// of cnt/idx/phase/active. This keeps every output consistent with the state
// of the cycle it appears in, with no input-to-output combinational path.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEAD_CYC  = 2,
    parameter int BLINK_DIV = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  en,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  code,
    output logic [3:0]  dig_n,
    output logic        pending,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD  = CW'(DEAD_CYC);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

    // Slot FSM: DEAD for the first DEAD_CYC cycles of a slot, DRIVE for the rest.
    typedef enum logic {
        SLOT_DEAD  = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_t;

    slot_t          slot_q, slot_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [15:0]    active_q, active_d;
    logic           pending_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic           phase_q, phase_d;
    logic [3:0]     code_d;
    logic [3:0]     dig_n_d;
    logic           frame_tick_d;
    logic           slot_wrap;
    logic           frame_end;
    logic           blanked;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= (DEAD_CYC > 0) ? SLOT_DEAD : SLOT_DRIVE;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            shadow_q   <= 16'h0000;
            active_q   <= 16'h0000;
            pending    <= 1'b0;
            bcnt_q     <= '0;
            phase_q    <= 1'b0;
            code       <= 4'h0;
            dig_n      <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending    <= pending_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            code       <= code_d;
            dig_n      <= dig_n_d;
            frame_tick <= frame_tick_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending;
        bcnt_d       = bcnt_q;
        phase_d      = phase_q;
        code_d       = 4'h0;
        dig_n_d      = 4'b1111;
        frame_tick_d = 1'b0;
        blanked      = 1'b0;

        slot_wrap = (cnt_q == CNT_LAST);
        frame_end = slot_wrap && (idx_q == 2'd3);

        // Slot prescaler and digit index
        if (slot_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Double buffer. A load on the frame-end cycle bypasses the shadow,
        // so the newest value wins and nothing stale stays pending.
        if (frame_end) begin
            if (load) begin
                active_d  = din;
                shadow_d  = din;
                pending_d = 1'b0;
            end else if (pending) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
            if (bcnt_q == BCNT_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end else if (load) begin
            shadow_d  = din;
            pending_d = 1'b1;
        end

        // Slot FSM transitions, evaluated on the next counter value
        case (slot_q)
            SLOT_DEAD:  if (cnt_d >= CNT_DEAD) slot_d = SLOT_DRIVE;
            SLOT_DRIVE: if (cnt_d < CNT_DEAD)  slot_d = SLOT_DEAD;
            default:    slot_d = SLOT_DEAD;
        endcase

        // Output values for the upcoming cycle
        blanked = !en[idx_d] || (blink_mask[idx_d] && phase_d);
        if ((slot_d == SLOT_DRIVE) && !blanked) begin
            dig_n_d[idx_d] = 1'b0;
        end
        code_d       = active_d[{idx_d, 2'b00} +: 4];
        frame_tick_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
    end

endmodule
